id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register and EX operand front end; directly upstream of the EX-stage ALU.
//  Registers decoded ID fields, applies EX/MEM and MEM/WB forwarding, and selects alu_src_a/alu_src_b.
//  Emits alu_op; bubbles carry `ALU_NOP (ctrl_encode_def.v).
//  Holds the entry across stalls and refreshes held operands so values retiring during a stall are kept.
// PARAMETERS
//  DATA_W  32  datapath width
//  REG_AW  5   register-address width
//  OP_W    5   alu_op width (matches ALU)
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       async active-low reset
//  stall          in   1       hold EX entry
//  flush          in   1       replace EX entry with bubble; priority over stall
//  id_valid       in   1       ID holds a real instruction
//  id_rs_addr/id_rt_addr in REG_AW  source registers
//  id_rs_data/id_rt_data in DATA_W  register-file read data
//  id_rd_addr     in   REG_AW  destination register
//  id_imm32       in   DATA_W  extended immediate
//  id_shamt       in   5       shift amount field
//  id_src_a_sel   in   2       0=rs, 1=zext shamt, 2=zext rs[4:0], 3=zero
//  id_src_b_sel   in   1       0=rt, 1=imm32
//  id_alu_op      in   OP_W    ALU operation
//  id_reg_write/id_mem_read/id_mem_write in 1  control bits
//  exm_reg_write/exm_rd_addr/exm_result in 1/REG_AW/DATA_W  EX/MEM forward source
//  wb_reg_write/wb_rd_addr/wb_data      in 1/REG_AW/DATA_W  MEM/WB forward source
//  alu_src_a/alu_src_b  out  DATA_W  ALU operands (combinational from regs + forwarding)
//  alu_op         out  OP_W    registered op
//  ex_store_data  out  DATA_W  forwarded rt, for stores
//  ex_rd_addr/ex_reg_write/ex_mem_read/ex_mem_write/ex_valid  out  registered
//  load_use_stall out  1       hazard request (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): all registers 0, alu_op=`ALU_NOP, ex_valid=0; stall/flush ignored.
//  Each posedge, priority: flush > stall > load.
//   flush: bubble (ex_valid=0, alu_op=`ALU_NOP, ctrl bits 0, operands 0).
//   stall: hold all fields; rs_q<=fwd_rs, rt_q<=fwd_rt (refresh).
//   load:  id_valid=1 -> capture ID fields; id_valid=0 -> bubble.
//  Forwarding (combinational, per source s in {rs,rt}):
//   addr==0 -> s_q; else exm_reg_write & exm_rd_addr==addr -> exm_result;
//   else wb_reg_write & wb_rd_addr==addr -> wb_data; else s_q. EX/MEM beats MEM/WB.
//  alu_src_a: per sel_q: fwd_rs | {27'b0,shamt_q} | {27'b0,fwd_rs[4:0]} | 0.
//  alu_src_b: sel_q ? imm_q : fwd_rt. ex_store_data = fwd_rt.
//  Latency: ID -> ALU operands 1 cycle; forwarding adds 0.
//  Bubble: alu_src_a/b still driven deterministically from zeroed regs (0 unless forwarded).
//  Simultaneous flush+stall: flush wins. Reset mid-stall: entry lost, bubble.
// CONFIGURATION
//  LOAD_USE_DETECT_EN defined:
//   load_use_stall = ex_valid & ex_mem_read & ex_rd_addr!=0
//                    & (id_rs_addr==ex_rd_addr | id_rt_addr==ex_rd_addr) & id_valid.
//   Combinational; driving stall/insert-bubble is the hazard unit's job.
//  Not defined: load_use_stall tied 0; no comparator logic.
// TESTING
//  Reset: rst_n=0 mid-cycle -> alu_op=`ALU_NOP, ex_valid=0, all ctrl 0 immediately.
//  Plain load: rs=5'd1 data 32'h10, imm=32'h4, src_b_sel=1, op=ADDU -> next cycle src_a=32'h10, src_b=32'h4.
//  Priority: exm and wb both write r3 (32'hAAAA / 32'hBBBB), rs=r3 -> alu_src_a=32'hAAAA; exm drops -> 32'hBBBB; r0 never forwarded.
//  Shift: src_a_sel=1, shamt=5'd7, rt=32'h1 -> src_a=32'h7, src_b=32'h1.
//  Shift: src_a_sel=2 with fwd rs=32'hFFFF_FF23 -> src_a=32'h3.
//  Stall refresh: stall 2 cycles, wb writes rs=32'h55 in cycle 1 then idles -> src_a stays 32'h55 after release.
//  Flush+stall same edge -> bubble, alu_op=`ALU_NOP.
//  With LOAD_USE_DETECT_EN: EX lw r8, ID rt=r8 -> load_use_stall=1; rd=r0 -> 0.
//  Without LOAD_USE_DETECT_EN: same stimulus -> load_use_stall=0.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//
// Purpose:
//   ID/EX pipeline register plus the EX-stage operand front end that sits
//   directly in front of the ALU. It registers the decoded ID fields, resolves
//   EX/MEM and MEM/WB forwarding for both source registers, and selects the two
//   ALU operands. Empty slots (bubbles) carry `ALU_NOP on alu_op.
//   While stalled, the held entry keeps all of its fields. The held rs/rt
//   values are rewritten with their forwarded values, so a result that retires
//   during the stall is still visible after the stall ends.
//
// Configuration macro:
//   LOAD_USE_DETECT_EN - when defined, load_use_stall flags an ID instruction
//                        that reads the destination of a load sitting in EX.
//                        When undefined, load_use_stall is tied low.
//
// Parameters:
//   DATA_W (32) datapath width, REG_AW (5) register address width,
//   OP_W (5) alu_op width
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   stall, flush            hold the EX entry / replace it with a bubble
//                           (flush has priority)
//   id_valid                ID holds a real instruction
//   id_rs_addr, id_rt_addr  source register addresses
//   id_rs_data, id_rt_data  register-file read data
//   id_rd_addr              destination register
//   id_imm32, id_shamt      extended immediate, shift amount
//   id_src_a_sel            0=rs, 1=zext shamt, 2=zext rs[4:0], 3=zero
//   id_src_b_sel            0=rt, 1=imm32
//   id_alu_op               ALU operation
//   id_reg_write, id_mem_read, id_mem_write   control bits
//   exm_reg_write, exm_rd_addr, exm_result    EX/MEM forward source
//   wb_reg_write, wb_rd_addr, wb_data         MEM/WB forward source
//   alu_src_a, alu_src_b    ALU operands (combinational)
//   alu_op                  registered ALU operation
//   ex_store_data           forwarded rt, used as store data
//   ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write, ex_valid  EX entry
//   load_use_stall          load-use hazard request
// ---------------------------------------------------------------------------
`ifndef ALU_NOP
`define ALU_NOP 5'b00000
`endif

module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_imm32,
  input  logic [4:0]        id_shamt,
  input  logic [1:0]        id_src_a_sel,
  input  logic              id_src_b_sel,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd_addr,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] alu_src_a,
  output logic [DATA_W-1:0] alu_src_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_valid,
  output logic              load_use_stall
);

  localparam logic [OP_W-1:0] L_ALU_NOP = OP_W'(`ALU_NOP);

  logic              r_valid;
  logic [REG_AW-1:0] r_rs_addr;
  logic [REG_AW-1:0] r_rt_addr;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [REG_AW-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_shamt;
  logic [1:0]        r_src_a_sel;
  logic              r_src_b_sel;
  logic [OP_W-1:0]   r_alu_op;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;

  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;
  logic              w_bubble;

  // Forwarding mux for one source. r0 is hard-wired, so it never takes a
  // forwarded value. EX/MEM is checked first because it is the younger result.
  function automatic logic [DATA_W-1:0] fwdSel(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] held
  );
    if (addr == '0)
      return held;
    else if (exm_reg_write && (exm_rd_addr == addr))
      return exm_result;
    else if (wb_reg_write && (wb_rd_addr == addr))
      return wb_data;
    else
      return held;
  endfunction

  assign w_fwd_rs = fwdSel(r_rs_addr, r_rs_data);
  assign w_fwd_rt = fwdSel(r_rt_addr, r_rt_data);

  // A flush always produces a bubble. An unstalled edge with no valid ID
  // instruction also produces a bubble.
  assign w_bubble = flush | (~stall & ~id_valid);

  // EX entry register. A stall keeps all fields but rewrites the operand
  // values with their forwarded versions. A bubble clears every field so that
  // the operand outputs stay deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_bubble) begin
      if (!rst_n || flush || !stall) begin
        r_valid     <= 1'b0;
        r_rs_addr   <= '0;
        r_rt_addr   <= '0;
        r_rs_data   <= '0;
        r_rt_data   <= '0;
        r_rd_addr   <= '0;
        r_imm       <= '0;
        r_shamt     <= '0;
        r_src_a_sel <= '0;
        r_src_b_sel <= 1'b0;
        r_alu_op    <= L_ALU_NOP;
        r_reg_write <= 1'b0;
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
      end
    end else if (stall) begin
      r_rs_data <= w_fwd_rs;
      r_rt_data <= w_fwd_rt;
    end else begin
      r_valid     <= 1'b1;
      r_rs_addr   <= id_rs_addr;
      r_rt_addr   <= id_rt_addr;
      r_rs_data   <= id_rs_data;
      r_rt_data   <= id_rt_data;
      r_rd_addr   <= id_rd_addr;
      r_imm       <= id_imm32;
      r_shamt     <= id_shamt;
      r_src_a_sel <= id_src_a_sel;
      r_src_b_sel <= id_src_b_sel;
      r_alu_op    <= id_alu_op;
      r_reg_write <= id_reg_write;
      r_mem_read  <= id_mem_read;
      r_mem_write <= id_mem_write;
    end
  end

  // Operand A selection. The shift-amount variants zero-extend a 5-bit value.
  always_comb begin
    alu_src_a = '0;
    case (r_src_a_sel)
      2'd0:    alu_src_a = w_fwd_rs;
      2'd1:    alu_src_a = {{(DATA_W-5){1'b0}}, r_shamt};
      2'd2:    alu_src_a = {{(DATA_W-5){1'b0}}, w_fwd_rs[4:0]};
      default: alu_src_a = '0;
    endcase
  end

  assign alu_src_b     = r_src_b_sel ? r_imm : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign alu_op        = r_alu_op;
  assign ex_rd_addr    = r_rd_addr;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_valid      = r_valid;

`ifdef LOAD_USE_DETECT_EN
  // A load in EX whose destination is read by the ID instruction. r0 is
  // excluded because it cannot carry a loaded value.
  assign load_use_stall = r_valid & r_mem_read & (r_rd_addr != '0)
                        & ((id_rs_addr == r_rd_addr) | (id_rt_addr == r_rd_addr))
                        & id_valid;
`else
  assign load_use_stall = 1'b0;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
`ifndef ALU_NOP
`define ALU_NOP 5'b00000
`endif

module tb_id_ex_operand_stage;

  localparam logic [4:0] NOP     = `ALU_NOP;
  localparam logic [4:0] OP_ADDU = 5'd2;
  localparam logic [4:0] OP_SLL  = 5'd9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt, id_alu_op;
  logic [31:0] id_rs_data, id_rt_data, id_imm32;
  logic [1:0]  id_src_a_sel;
  logic        id_src_b_sel, id_reg_write, id_mem_read, id_mem_write;
  logic        exm_reg_write, wb_reg_write;
  logic [4:0]  exm_rd_addr, wb_rd_addr;
  logic [31:0] exm_result, wb_data;
  logic [31:0] alu_src_a, alu_src_b, ex_store_data;
  logic [4:0]  alu_op, ex_rd_addr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_valid, load_use_stall;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_rd_addr(id_rd_addr), .id_imm32(id_imm32), .id_shamt(id_shamt),
    .id_src_a_sel(id_src_a_sel), .id_src_b_sel(id_src_b_sel), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_valid(ex_valid), .load_use_stall(load_use_stall)
  );

  // Reference model: the instruction currently in EX, as a record.
  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd, shamt, op;
    logic [31:0] rsv, rtv, imm;
    logic [1:0]  sa;
    logic        sb, rw, mr, mw;
  } entry_t;

  entry_t mdl;

  function automatic entry_t emptySlot();
    entry_t e;
    e.valid = 0; e.rs = 0; e.rt = 0; e.rd = 0; e.shamt = 0; e.op = NOP;
    e.rsv = 0; e.rtv = 0; e.imm = 0; e.sa = 0; e.sb = 0;
    e.rw = 0; e.mr = 0; e.mw = 0;
    return e;
  endfunction

  // Newest architectural value of a register as seen from EX.
  function automatic logic [31:0] newestValue(input logic [4:0] r, input logic [31:0] held);
    if (r != 0 && exm_reg_write && exm_rd_addr == r) return exm_result;
    if (r != 0 && wb_reg_write && wb_rd_addr == r) return wb_data;
    return held;
  endfunction

  function automatic entry_t nextEntry(input entry_t cur);
    entry_t n;
    if (flush) return emptySlot();
    if (stall) begin
      n = cur;
      n.rsv = newestValue(cur.rs, cur.rsv);
      n.rtv = newestValue(cur.rt, cur.rtv);
      return n;
    end
    if (!id_valid) return emptySlot();
    n.valid = 1; n.rs = id_rs_addr; n.rt = id_rt_addr; n.rd = id_rd_addr;
    n.shamt = id_shamt; n.op = id_alu_op; n.rsv = id_rs_data; n.rtv = id_rt_data;
    n.imm = id_imm32; n.sa = id_src_a_sel; n.sb = id_src_b_sel;
    n.rw = id_reg_write; n.mr = id_mem_read; n.mw = id_mem_write;
    return n;
  endfunction

  function automatic logic [31:0] expA();
    logic [31:0] v;
    v = newestValue(mdl.rs, mdl.rsv);
    case (mdl.sa)
      2'd0: return v;
      2'd1: return 32'(mdl.shamt);
      2'd2: return v % 32;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] expB();
    return mdl.sb ? mdl.imm : newestValue(mdl.rt, mdl.rtv);
  endfunction

  function automatic logic expLoadUse();
`ifdef LOAD_USE_DETECT_EN
    return mdl.valid && mdl.mr && mdl.rd != 0 && id_valid
           && (id_rs_addr == mdl.rd || id_rt_addr == mdl.rd);
`else
    return 1'b0;
`endif
  endfunction

  task automatic clockEdge();
    entry_t n;
    n = nextEntry(mdl);
    @(posedge clk);
    mdl = n;
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [31:0] rsd,
                               input logic [4:0] rt, input logic [31:0] rtd,
                               input logic [4:0] rd, input logic [31:0] imm,
                               input logic [4:0] sh, input logic [1:0] sa,
                               input logic sb, input logic [4:0] op,
                               input logic rw, input logic mr, input logic mw);
    id_valid = 1; id_rs_addr = rs; id_rs_data = rsd; id_rt_addr = rt; id_rt_data = rtd;
    id_rd_addr = rd; id_imm32 = imm; id_shamt = sh; id_src_a_sel = sa;
    id_src_b_sel = sb; id_alu_op = op; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic clearForward();
    exm_reg_write = 0; exm_rd_addr = 0; exm_result = 0;
    wb_reg_write = 0; wb_rd_addr = 0; wb_data = 0;
  endtask

  task automatic test_reset();
    applyStimulus(5'd1, 32'h10, 5'd2, 32'h20, 5'd3, 32'h4, 5'd0, 2'd0, 1'b0, OP_ADDU, 1, 1, 1);
    clockEdge();
    #2;
    rst_n = 0;
    stall = 1;
    #1;
    mdl = emptySlot();
    nCompared++;
    if (alu_op !== NOP) begin nMismatched++; $display("[TB] FAIL reset_alu_op got %h want %h", alu_op, NOP); end
    nCompared++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 4'b0) begin
      nMismatched++; $display("[TB] FAIL reset_ctrl got %b want 0000", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write});
    end
    nCompared++;
    if (alu_src_a !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_src_a got %h want 0", alu_src_a); end
    @(posedge clk);
    #1;
    nCompared++;
    if (ex_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ignores_stall got %b want 0", ex_valid); end
    @(negedge clk);
    rst_n = 1;
    stall = 0;
    id_valid = 0;
    clockEdge();
  endtask

  task automatic test_plain_load();
    applyStimulus(5'd1, 32'h10, 5'd2, 32'h99, 5'd5, 32'h4, 5'd0, 2'd0, 1'b1, OP_ADDU, 1, 0, 0);
    clockEdge();
    nCompared++;
    if (alu_src_a !== 32'h10) begin nMismatched++; $display("[TB] FAIL load_src_a got %h want 00000010", alu_src_a); end
    nCompared++;
    if (alu_src_b !== 32'h4) begin nMismatched++; $display("[TB] FAIL load_src_b got %h want 00000004", alu_src_b); end
    nCompared++;
    if ({ex_valid, alu_op, ex_rd_addr} !== {1'b1, OP_ADDU, 5'd5}) begin
      nMismatched++; $display("[TB] FAIL load_ctrl got v=%b op=%h rd=%0d want v=1 op=%h rd=5", ex_valid, alu_op, ex_rd_addr, OP_ADDU);
    end
    id_valid = 0;
    clockEdge();
    nCompared++;
    if ({ex_valid, alu_op} !== {1'b0, NOP}) begin
      nMismatched++; $display("[TB] FAIL idle_bubble got v=%b op=%h want v=0 op=%h", ex_valid, alu_op, NOP);
    end
  endtask

  task automatic test_forward_priority();
    applyStimulus(5'd3, 32'h1111, 5'd0, 32'h77, 5'd4, 32'h0, 5'd0, 2'd0, 1'b0, OP_ADDU, 1, 0, 0);
    clockEdge();
    exm_reg_write = 1; exm_rd_addr = 3; exm_result = 32'hAAAA;
    wb_reg_write = 1; wb_rd_addr = 3; wb_data = 32'hBBBB;
    #1;
    nCompared++;
    if (alu_src_a !== 32'hAAAA) begin nMismatched++; $display("[TB] FAIL fwd_exm_wins got %h want 0000aaaa", alu_src_a); end
    exm_reg_write = 0;
    #1;
    nCompared++;
    if (alu_src_a !== 32'hBBBB) begin nMismatched++; $display("[TB] FAIL fwd_wb got %h want 0000bbbb", alu_src_a); end
    exm_reg_write = 1; exm_rd_addr = 0; exm_result = 32'hDEAD;
    wb_rd_addr = 0; wb_data = 32'hBEEF;
    #1;
    nCompared++;
    if ({alu_src_b, ex_store_data} !== {32'h77, 32'h77}) begin
      nMismatched++; $display("[TB] FAIL fwd_r0_blocked got b=%h st=%h want 00000077", alu_src_b, ex_store_data);
    end
    clearForward();
  endtask

  task automatic test_shift();
    applyStimulus(5'd0, 32'h0, 5'd2, 32'h1, 5'd6, 32'h0, 5'd7, 2'd1, 1'b0, OP_SLL, 1, 0, 0);
    clockEdge();
    nCompared++;
    if ({alu_src_a, alu_src_b} !== {32'h7, 32'h1}) begin
      nMismatched++; $display("[TB] FAIL shift_shamt got a=%h b=%h want a=00000007 b=00000001", alu_src_a, alu_src_b);
    end
    applyStimulus(5'd4, 32'h0, 5'd2, 32'h1, 5'd6, 32'h0, 5'd0, 2'd2, 1'b0, OP_SLL, 1, 0, 0);
    clockEdge();
    exm_reg_write = 1; exm_rd_addr = 4; exm_result = 32'hFFFF_FF23;
    #1;
    nCompared++;
    if (alu_src_a !== 32'h3) begin nMismatched++; $display("[TB] FAIL shift_rs_low got %h want 00000003", alu_src_a); end
    clearForward();
  endtask

  task automatic test_stall_refresh();
    applyStimulus(5'd6, 32'h11, 5'd0, 32'h0, 5'd7, 32'h0, 5'd0, 2'd0, 1'b0, OP_ADDU, 1, 0, 0);
    clockEdge();
    applyStimulus(5'd9, 32'h999, 5'd9, 32'h999, 5'd9, 32'h9, 5'd9, 2'd3, 1'b1, 5'd9, 0, 1, 1);
    stall = 1;
    wb_reg_write = 1; wb_rd_addr = 6; wb_data = 32'h55;
    clockEdge();
    clearForward();
    clockEdge();
    stall = 0;
    #1;
    nCompared++;
    if (alu_src_a !== 32'h55) begin nMismatched++; $display("[TB] FAIL stall_refresh got %h want 00000055", alu_src_a); end
    nCompared++;
    if ({ex_valid, alu_op, ex_rd_addr, ex_mem_read} !== {1'b1, OP_ADDU, 5'd7, 1'b0}) begin
      nMismatched++; $display("[TB] FAIL stall_hold got v=%b op=%h rd=%0d mr=%b want v=1 op=%h rd=7 mr=0", ex_valid, alu_op, ex_rd_addr, ex_mem_read, OP_ADDU);
    end
  endtask

  task automatic test_flush_stall();
    applyStimulus(5'd1, 32'h5, 5'd2, 32'h6, 5'd3, 32'h0, 5'd0, 2'd0, 1'b0, OP_ADDU, 1, 0, 1);
    clockEdge();
    flush = 1; stall = 1;
    clockEdge();
    flush = 0; stall = 0;
    nCompared++;
    if ({ex_valid, alu_op, ex_reg_write, ex_mem_write} !== {1'b0, NOP, 2'b00}) begin
      nMismatched++; $display("[TB] FAIL flush_over_stall got v=%b op=%h rw=%b mw=%b want bubble", ex_valid, alu_op, ex_reg_write, ex_mem_write);
    end
    nCompared++;
    if ({alu_src_a, alu_src_b} !== 64'h0) begin
      nMismatched++; $display("[TB] FAIL flush_operands got a=%h b=%h want 0", alu_src_a, alu_src_b);
    end
  endtask

  task automatic test_load_use();
    logic want;
`ifdef LOAD_USE_DETECT_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    applyStimulus(5'd1, 32'h100, 5'd8, 32'h0, 5'd8, 32'h0, 5'd0, 2'd0, 1'b1, OP_ADDU, 1, 1, 0);
    clockEdge();
    id_rs_addr = 5'd1; id_rt_addr = 5'd8; id_valid = 1;
    #1;
    nCompared++;
    if (load_use_stall !== want) begin nMismatched++; $display("[TB] FAIL load_use_hit got %b want %b", load_use_stall, want); end
    id_valid = 0;
    #1;
    nCompared++;
    if (load_use_stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_use_id_idle got %b want 0", load_use_stall); end
    applyStimulus(5'd1, 32'h100, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 2'd0, 1'b1, OP_ADDU, 1, 1, 0);
    clockEdge();
    id_rs_addr = 5'd0; id_rt_addr = 5'd0;
    #1;
    nCompared++;
    if (load_use_stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_use_r0 got %b want 0", load_use_stall); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 7), $urandom, $urandom_range(0, 7), $urandom,
                    $urandom_range(0, 7), $urandom, 5'($urandom), 2'($urandom),
                    1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      id_valid = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      exm_reg_write = 1'($urandom); exm_rd_addr = $urandom_range(0, 7); exm_result = $urandom;
      wb_reg_write = 1'($urandom); wb_rd_addr = $urandom_range(0, 7); wb_data = $urandom;
      clockEdge();
      nCompared++;
      if ({alu_src_a, alu_src_b, ex_store_data} !== {expA(), expB(), newestValue(mdl.rs == mdl.rs ? mdl.rt : 5'd0, mdl.rtv)}) begin
        nMismatched++;
        $display("[TB] FAIL rand_operands cyc=%0d got a=%h b=%h st=%h want a=%h b=%h st=%h",
                 i, alu_src_a, alu_src_b, ex_store_data, expA(), expB(), newestValue(mdl.rt, mdl.rtv));
      end
      nCompared++;
      if ({ex_valid, alu_op, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall}
          !== {mdl.valid, mdl.op, mdl.rd, mdl.rw, mdl.mr, mdl.mw, expLoadUse()}) begin
        nMismatched++;
        $display("[TB] FAIL rand_ctrl cyc=%0d got v=%b op=%h rd=%0d rw/mr/mw=%b%b%b lu=%b want v=%b op=%h rd=%0d rw/mr/mw=%b%b%b lu=%b",
                 i, ex_valid, alu_op, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall,
                 mdl.valid, mdl.op, mdl.rd, mdl.rw, mdl.mr, mdl.mw, expLoadUse());
      end
    end
    stall = 0; flush = 0; id_valid = 0;
    clearForward();
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0; id_valid = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0);
    id_valid = 0;
    clearForward();
    mdl = emptySlot();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    test_reset();
    test_plain_load();
    test_forward_priority();
    test_shift();
    test_stall_refresh();
    test_flush_stall();
    test_load_use();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
